// File: rtl/imem_port_ctrl_pkg.sv
// Shared types and widths for the instruction-memory port controller.
// Widths mirror WORD_SIZE / BLOCK_SIZE from define.v.
package imem_port_ctrl_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int BLOCK_SIZE = 1024;
  localparam int LAT_W      = 4;  // holds MEM_LAT-1 for MEM_LAT up to 15
  localparam int CNT_W      = 4;  // holds STARVE_MAX up to 15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ACK  = 2'd3
  } state_e;

endpackage

// File: rtl/imem_port_ctrl_if.sv
// Bundle of the fetch, loader and instmem-side signals of the port controller.
// The slave modport is the controller's view; the master modport is its environment.
interface imem_port_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int BLK_W  = 1024
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [BLK_W-1:0]  f_blk0;
  logic [BLK_W-1:0]  f_blk1;
  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic [BLK_W-1:0]  w_data;
  logic              w_ack;
  logic [ADDR_W-1:0] mem_in;
  logic              mem_readable;
  logic              mem_writable;
  logic [BLK_W-1:0]  mem_write;
  logic [BLK_W-1:0]  mem_out1;
  logic [BLK_W-1:0]  mem_out2;
  logic              busy;

  modport slave (
    input  f_req, f_addr, w_req, w_addr, w_data, mem_out1, mem_out2,
    output f_ack, f_blk0, f_blk1, w_ack, mem_in, mem_readable, mem_writable,
           mem_write, busy
  );

  modport master (
    output f_req, f_addr, w_req, w_addr, w_data, mem_out1, mem_out2,
    input  f_ack, f_blk0, f_blk1, w_ack, mem_in, mem_readable, mem_writable,
           mem_write, busy
  );
endinterface

// File: rtl/imem_port_ctrl_arb2.sv
// Two-way arbiter: fetch wins contested grants until the loader has been
// passed over STARVE_MAX times in a row, then the loader is forced through.
module imem_arb2
  import imem_port_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic f_req,
  input  logic w_req,
  input  logic grant,
  output logic sel_w
);

  logic [CNT_W-1:0] starve_q;

  assign sel_w = w_req && (!f_req || (starve_q == CNT_W'(STARVE_MAX)));

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (grant) begin
      if (sel_w) begin
        starve_q <= '0;
      end else if (w_req && (starve_q != CNT_W'(STARVE_MAX))) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_port_ctrl.sv
// Sequencer for the single instmem port: arbitrates fetch refills against loader
// writes, holds the memory inputs for MEM_LAT cycles, then acknowledges.
module imem_port_ctrl
  import imem_port_ctrl_pkg::*;
#(
  parameter int ADDR_W     = WORD_SIZE,
  parameter int BLK_W      = BLOCK_SIZE,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic             clk,
  input logic             rst,
  imem_port_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_q;
  logic              grant, sel_w, done;
  logic [ADDR_W-1:0] mem_in_q;
  logic [BLK_W-1:0]  mem_write_q, blk0_q, blk1_q;
  logic              rd_en_q, wr_en_q, f_ack_q, w_ack_q;

  imem_arb2 #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .f_req (bus.f_req),
    .w_req (bus.w_req),
    .grant (grant),
    .sel_w (sel_w)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d = state_q;
    grant   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.f_req || bus.w_req) begin
          grant   = 1'b1;
          state_d = sel_w ? WR : RD;
        end
      end
      RD, WR: begin
        if (lat_q == '0) begin
          done    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      mem_in_q    <= '0;
      mem_write_q <= '0;
      blk0_q      <= '0;
      blk1_q      <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      f_ack_q     <= 1'b0;
      w_ack_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      f_ack_q <= 1'b0;
      w_ack_q <= 1'b0;
      if (grant) begin
        mem_in_q <= sel_w ? bus.w_addr : bus.f_addr;
        if (sel_w) mem_write_q <= bus.w_data;
        rd_en_q <= !sel_w;
        wr_en_q <= sel_w;
        lat_q   <= LAT_W'(MEM_LAT - 1);
      end else if (done) begin
        // Address and write block stay put; only the enables drop.
        rd_en_q <= 1'b0;
        wr_en_q <= 1'b0;
        if (state_q == RD) begin
          blk0_q  <= bus.mem_out1;
          blk1_q  <= bus.mem_out2;
          f_ack_q <= 1'b1;
        end else begin
          w_ack_q <= 1'b1;
        end
      end else if (state_q == RD || state_q == WR) begin
        lat_q <= lat_q - 1'b1;
      end
    end
  end

  assign bus.mem_in       = mem_in_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.mem_readable = rd_en_q;
  assign bus.mem_writable = wr_en_q;
  assign bus.f_blk0       = blk0_q;
  assign bus.f_blk1       = blk1_q;
  assign bus.f_ack        = f_ack_q;
  assign bus.w_ack        = w_ack_q;
  assign bus.busy         = (state_q != IDLE);

endmodule
